// File: rtl/tone_synth_mc.sv
// Multi-channel square-wave tone synthesiser: per-channel 5-bit note code -> square wave, plus
// a registered voice-count mix. Ports: iclk, rst (sync, active-high), code[NUM_CH*5], speaker,
// ack, mix; oct_up only when OCTAVE_SHIFT_EN is defined (latched octave-up per channel).
module tone_synth_mc #(
  parameter int CLK_HZ = 50000000,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20
) (
  input  logic                         iclk,
  input  logic                         rst,
  input  logic [NUM_CH*5-1:0]          code,
`ifdef OCTAVE_SHIFT_EN
  input  logic                         oct_up,
`endif
  output logic [NUM_CH-1:0]            speaker,
  output logic [NUM_CH-1:0]            ack,
  output logic [$clog2(NUM_CH+1)-1:0]  mix
);

  localparam int MW = $clog2(NUM_CH+1);

  typedef enum logic {IDLE, RUN} st_t;

  function automatic int freq_of(input int c);
    case (c)
      1:  return 494;   2:  return 554;   3:  return 622;   4:  return 659;
      5:  return 740;   6:  return 831;   7:  return 932;
      11: return 988;   12: return 1109;  13: return 1245;  14: return 1318;
      15: return 1480;  16: return 1661;  17: return 1865;
      21: return 1976;  22: return 2218;  23: return 2490;  24: return 2636;
      25: return 2960;  26: return 3322;  27: return 3730;
      default: return 0;
    endcase
  endfunction

  // Zero marks a rest/invalid code; every playable code gets at least 1.
  function automatic logic [CNT_W-1:0] half_of(input int c);
    int f;
    int h;
    f = freq_of(c);
    if (f == 0) return '0;
    h = CLK_HZ / (2 * f);
    if (h < 1) h = 1;
    return CNT_W'(h);
  endfunction

  logic [CNT_W-1:0] half_tab [32];
  for (genvar i = 0; i < 32; i++) begin : g_tab
    assign half_tab[i] = half_of(i);
  end

  logic oct_in;
`ifdef OCTAVE_SHIFT_EN
  assign oct_in = oct_up;
`else
  assign oct_in = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    st_t              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] h_base, h_half, h_eff;
    logic [4:0]       act_q, act_d, cin;
    logic             oct_q, oct_d;
    logic             spk_q, spk_d;
    logic             ack_q, ack_d;
    logic             cin_ok;

    assign cin    = code[5*g +: 5];
    assign cin_ok = (half_tab[cin] != '0);
    assign h_base = half_tab[act_q];
    assign h_half = h_base >> 1;
    assign h_eff  = oct_q ? ((h_half == '0) ? CNT_W'(1) : h_half) : h_base;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      act_d = act_q;
      oct_d = oct_q;
      spk_d = spk_q;
      ack_d = 1'b0;
      case (st_q)
        IDLE: begin
          if (cin_ok) begin
            act_d = cin;
            oct_d = oct_in;
            cnt_d = '0;
            spk_d = 1'b1;
            ack_d = 1'b1;
            st_d  = RUN;
          end
        end
        RUN: begin
          if (cnt_q == h_eff - 1'b1) begin
            cnt_d = '0;
            if (spk_q) begin
              spk_d = 1'b0;
            end else if (cin == act_q && oct_in == oct_q) begin
              // Period boundary with nothing changed: start the next period.
              spk_d = 1'b1;
            end else if (cin_ok) begin
              // An octave-only change reloads silently; a new note is acknowledged.
              ack_d = (cin != act_q);
              act_d = cin;
              oct_d = oct_in;
              spk_d = 1'b1;
            end else begin
              act_d = '0;
              oct_d = 1'b0;
              st_d  = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge iclk) begin
      if (rst) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        act_q <= '0;
        oct_q <= 1'b0;
        spk_q <= 1'b0;
        ack_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        act_q <= act_d;
        oct_q <= oct_d;
        spk_q <= spk_d;
        ack_q <= ack_d;
      end
    end

    assign speaker[g] = spk_q;
    assign ack[g]     = ack_q;
  end

  // Popcount of the registered speakers, registered again: mix trails speaker by one cycle.
  logic [MW-1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + MW'(speaker[i]);
  end

  always_ff @(posedge iclk) begin
    if (rst) mix <= '0;
    else     mix <= pop;
  end

endmodule
